gray_input_capture: RTL and testbench



---
 rtl/gray_pkg.sv | 25 ++
 rtl/input_synchronizer.sv | 32 +++
 rtl/gray_input_capture.sv | 90 +++++++++
 tb/tb_gray_input_capture.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for the Gray-code input path.
//   CODE_W  : width of the switch code (fixed at 4)
//   state_t : debounce FSM states
//   g2b     : Gray-to-binary conversion, also used by verification models
package gray_pkg;

    localparam int CODE_W = 4;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CODE_W-1:0] g2b(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// input_synchronizer
// Two-flop synchronizer for asynchronous level inputs (switches, buttons).
// Each bit is synchronized independently; callers must tolerate skew between bits.
//   clk : system clock
//   rst : synchronous, active-high reset (clears both stages)
//   d   : asynchronous input, WIDTH bits
//   q   : synchronized output, two cycles behind d
module input_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge; blocking here would collapse
    // the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/gray_input_capture.sv
// gray_input_capture
// Synchronizes and debounces a Gray-coded switch input, converts each accepted
// value to binary and marks it with a one-cycle pulse.
//   DEBOUNCE_CYCLES : cycles a change must hold steady before acceptance (>= 1)
//   CODE_W          : code width, must match gray_pkg::CODE_W
//   clk             : system clock
//   rst             : synchronous, active-high reset
//   gray_in         : raw asynchronous Gray code from the switches
//   binary_code     : last accepted value in binary, held between commits
//   code_valid      : one-cycle pulse when binary_code takes a new value
//   settling        : high while a candidate change is being timed
module gray_input_capture #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CODE_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] gray_in,
    output logic [CODE_W-1:0] binary_code,
    output logic              code_valid,
    output logic              settling
);

    import gray_pkg::*;

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1; keep at least one bit
    // so DEBOUNCE_CYCLES=1 still elaborates.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CODE_W-1:0] s2;
    logic [CODE_W-1:0] captured;
    logic [CODE_W-1:0] candidate;
    logic [CNT_W-1:0]  cnt;
    state_t            state;

    input_synchronizer #(
        .WIDTH (CODE_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STABLE;
            captured    <= '0;
            candidate   <= '0;
            cnt         <= '0;
            binary_code <= '0;
            code_valid  <= 1'b0;
        end else begin
            // NOTE: default the pulse low every cycle; only the commit branch
            // raises it, which guarantees a single-cycle pulse.
            code_valid <= 1'b0;
            case (state)
                STABLE: begin
                    if (s2 != captured) begin
                        state     <= SETTLE;
                        candidate <= s2;
                        cnt       <= '0;
                    end
                end
                SETTLE: begin
                    if (s2 == captured) begin
                        // Input returned to the accepted value: glitch, drop it.
                        state <= STABLE;
                    end else if (s2 != candidate) begin
                        // Still bouncing: time the new value from scratch.
                        candidate <= s2;
                        cnt       <= '0;
                    end else if (cnt == CNT_MAX) begin
                        captured    <= candidate;
                        binary_code <= g2b(candidate);
                        code_valid  <= 1'b1;
                        state       <= STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= STABLE;
            endcase
        end
    end

    assign settling = (state == SETTLE);

endmodule

// File: tb/tb_gray_input_capture.sv
module tb_gray_input_capture;

    localparam int DC = 4;
    // Drive at the negedge after posedge c -> pulse visible after posedge c+7.
    localparam int LATENCY = DC + 3;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic [3:0] binary_code;
    logic       code_valid;
    logic       settling;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int pulses   = 0;

    typedef struct {
        logic [3:0] bin;
        int         due;
    } exp_t;

    exp_t sb[$];

    gray_input_capture #(
        .DEBOUNCE_CYCLES (DC),
        .CODE_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gray_in     (gray_in),
        .binary_code (binary_code),
        .code_valid  (code_valid),
        .settling    (settling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Change the switches and register the pulse this change must produce.
    task automatic drive_expect(input logic [3:0] g, input logic [3:0] bin);
        exp_t e;
        gray_in = g;
        e.bin   = bin;
        e.due   = cycle + LATENCY;
        sb.push_back(e);
    endtask

    // Scoreboard side: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (code_valid === 1'b1) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                check("spurious_pulse", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_value", 32'(binary_code), 32'(e.bin));
                check("pulse_cycle", 32'(cycle), 32'(e.due));
            end
        end
    end

    initial begin
        bit saw;
        int wait_n;

        // Reset with switches at zero.
        rst     = 1'b1;
        gray_in = 4'b0000;
        tick(3);
        check("rst_binary", 32'(binary_code), 32'h0);
        check("rst_valid", 32'(code_valid), 32'h0);
        check("rst_settling", 32'(settling), 32'h0);
        rst = 1'b0;
        tick(20);
        check("idle_no_pulse", 32'(pulses), 32'd0);

        // Clean change 0000 -> 0110.
        drive_expect(4'b0110, 4'b0100);
        tick(15);
        check("clean_hold", 32'(binary_code), 32'h4);
        check("clean_pulses", 32'(pulses), 32'd1);

        // Glitch: 0111 for two cycles, then back to 0110.
        gray_in = 4'b0111;
        saw     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) gray_in = 4'b0110;
            tick(1);
            if (settling === 1'b1) saw = 1'b1;
        end
        check("glitch_saw_settle", 32'(saw), 32'd1);
        check("glitch_settle_low", 32'(settling), 32'h0);
        check("glitch_binary", 32'(binary_code), 32'h4);
        check("glitch_pulses", 32'(pulses), 32'd1);

        // Reset two cycles into SETTLE: the pending 1000 is discarded.
        gray_in = 4'b1000;
        wait_n  = 0;
        while (settling !== 1'b1 && wait_n < 10) begin
            tick(1);
            wait_n++;
        end
        check("midrst_entered_settle", 32'(settling), 32'h1);
        tick(1);
        rst = 1'b1;
        tick(3);
        check("midrst_binary", 32'(binary_code), 32'h0);
        check("midrst_settling", 32'(settling), 32'h0);
        check("midrst_pulses", 32'(pulses), 32'd1);
        // Switches still read 1000 at release: accepted through the normal path.
        rst = 1'b0;
        drive_expect(4'b1000, 4'b1111);
        tick(12);
        check("midrst_reaccept", 32'(binary_code), 32'hf);

        // Bounce between 0001 and 0011, then hold 0011.
        for (int i = 0; i < 5; i++) begin
            gray_in = (i % 2 == 0) ? 4'b0001 : 4'b0011;
            tick(2);
        end
        drive_expect(4'b0011, 4'b0010);
        tick(12);
        check("bounce_binary", 32'(binary_code), 32'h2);
        check("bounce_pulses", 32'(pulses), 32'd3);

        // Sweep all 16 Gray values; the binary index is the expected output.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] idx;
            logic [3:0] g;
            idx = 4'(i);
            g   = idx ^ (idx >> 1);
            drive_expect(g, idx);
            tick(10);
        end

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 50) begin
            tick(1);
            wait_n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("total_pulses", 32'(pulses), 32'd19);
        check("final_binary", 32'(binary_code), 32'hf);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
